// File: rtl/ysyx_23060203_exu_stage.sv
// Multi-cycle handshaked execute stage: IDU -> EXU -> WBU, with an aligned-word LSU port.
// Optional misaligned-access exceptions are enabled by defining EXU_MISALIGN_CHK_EN.
module ysyx_23060203_exu_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_funct,
  input  logic [RAW-1:0]    in_rd,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_src2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_alu_val,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_wen,
  output logic [RAW-1:0]    out_reg_waddr,
  output logic [XLEN-1:0]   out_reg_wdata,
  output logic [XLEN-1:0]   out_next_pc,
  output logic              out_exc,
  output logic [3:0]        out_exc_cause
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_CALRI  = 5'b00100;
  localparam logic [4:0] OP_CALRR  = 5'b01100;

  localparam logic [XLEN-1:0] ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] FOUR_X = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [NB-1:0]   ONE_NB = {{(NB-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  // log2 of access size in bytes; unknown encodings fall back to a word
  function automatic logic [1:0] acc_size(input logic [2:0] funct, input logic is_store);
    logic [1:0] sz;
    sz = 2'd2;
    case (funct)
      3'b000:  sz = 2'd0;
      3'b001:  sz = 2'd1;
      3'b100:  sz = is_store ? 2'd2 : 2'd0;
      3'b101:  sz = is_store ? 2'd2 : 2'd1;
      3'b011:  sz = (XLEN == 64) ? 2'd3 : 2'd2;
      default: sz = 2'd2;
    endcase
    return sz;
  endfunction

  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
    return (ONE_X << (32'd8 << sz)) - ONE_X;
  endfunction

  function automatic logic [OFFW-1:0] lane_mask(input logic [1:0] sz);
    return {OFFW{1'b1}} << sz;
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [XLEN-1:0] data, input logic [1:0] sz);
    logic [XLEN-1:0] wd;
    wd = data & size_mask(sz);
    for (int k = 0; k < OFFW; k++) begin
      if (k >= int'(sz)) begin
        wd = wd | (wd << (32'd8 << k));
      end else begin
        wd = wd;
      end
    end
    return wd;
  endfunction

  function automatic logic [NB-1:0] store_strb(input logic [1:0] sz, input logic [OFFW-1:0] off);
    logic [NB-1:0] full;
    full = (ONE_NB << (32'd1 << sz)) - ONE_NB;
    return full << off;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] rdata, input logic [OFFW-1:0] off,
                                                   input logic [1:0] sz, input logic uns);
    logic [XLEN-1:0] shifted, mask, res;
    shifted = rdata >> {off, 3'b000};
    mask    = size_mask(sz);
    res     = shifted & mask;
    if (!uns && ((shifted & mask & ~(mask >> 1)) != '0)) begin
      res = res | ~mask;
    end else begin
      res = res;
    end
    return res;
  endfunction

  function automatic logic br_taken(input logic [2:0] funct, input logic [XLEN-1:0] alu);
    logic t;
    t = 1'b0;
    case (funct)
      3'b000:         t = (alu == '0);
      3'b001:         t = (alu != '0);
      3'b100, 3'b110: t = alu[0];
      3'b101, 3'b111: t = ~alu[0];
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  state_e          state_q, state_d;
  logic            wen_q, wen_d;
  logic [RAW-1:0]  waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic            mwen_q, mwen_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic [XLEN-1:0] mwdata_q, mwdata_d;
  logic [NB-1:0]   mstrb_q, mstrb_d;
  logic [OFFW-1:0] ld_off_q, ld_off_d;
  logic [1:0]      ld_sz_q, ld_sz_d;
  logic            ld_uns_q, ld_uns_d;
  logic            exc_q, exc_d;
  logic [3:0]      cause_q, cause_d;

  logic            is_load_s, is_store_s, is_mem_s, mis_s, wen_dec_s;
  logic [1:0]      sz_s;
  logic [OFFW-1:0] off_s;
  logic [XLEN-1:0] pc4_s, npc_s;

  // Decode of the instruction currently presented by the IDU
  always_comb begin
    is_load_s  = (in_opcode == OP_LOAD);
    is_store_s = (in_opcode == OP_STORE);
    is_mem_s   = is_load_s | is_store_s;
    sz_s       = acc_size(in_funct, is_store_s);
    off_s      = in_alu_val[OFFW-1:0] & lane_mask(sz_s);
    pc4_s      = in_pc + FOUR_X;
`ifdef EXU_MISALIGN_CHK_EN
    mis_s      = is_mem_s && ((in_alu_val[OFFW-1:0] & ~lane_mask(sz_s)) != '0);
`else
    mis_s      = 1'b0;
`endif
    case (in_opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LOAD, OP_CALRI, OP_CALRR: wen_dec_s = 1'b1;
      default:                     wen_dec_s = 1'b0;
    endcase
    case (in_opcode)
      OP_JAL:    npc_s = in_pc + in_imm;
      OP_JALR:   npc_s = (in_src1 + in_imm) & ~ONE_X;
      OP_BRANCH: npc_s = br_taken(in_funct, in_alu_val) ? (in_pc + in_imm) : pc4_s;
      default:   npc_s = pc4_s;
    endcase
  end

  // Next-state and result capture
  always_comb begin
    state_d  = state_q;
    wen_d    = wen_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    npc_d    = npc_q;
    mwen_d   = mwen_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mstrb_d  = mstrb_q;
    ld_off_d = ld_off_q;
    ld_sz_d  = ld_sz_q;
    ld_uns_d = ld_uns_q;
    exc_d    = exc_q;
    cause_d  = cause_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wen_d    = wen_dec_s & ~mis_s;
          waddr_d  = in_rd;
          wdata_d  = in_alu_val;
          npc_d    = mis_s ? pc4_s : npc_s;
          mwen_d   = is_store_s;
          maddr_d  = {in_alu_val[XLEN-1:OFFW], {OFFW{1'b0}}};
          mwdata_d = is_store_s ? store_lanes(in_src2, sz_s) : '0;
          mstrb_d  = is_store_s ? store_strb(sz_s, off_s) : '0;
          ld_off_d = off_s;
          ld_sz_d  = sz_s;
          ld_uns_d = in_funct[2] & (in_funct != 3'b111);
          exc_d    = mis_s;
          cause_d  = mis_s ? (is_store_s ? 4'd6 : 4'd4) : 4'd0;
          state_d  = (is_mem_s && !mis_s) ? S_REQ : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          wdata_d = mwen_q ? wdata_q : load_extract(mem_rdata, ld_off_q, ld_sz_q, ld_uns_q);
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      npc_q    <= '0;
      mwen_q   <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mstrb_q  <= '0;
      ld_off_q <= '0;
      ld_sz_q  <= 2'd0;
      ld_uns_q <= 1'b0;
      exc_q    <= 1'b0;
      cause_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      npc_q    <= npc_d;
      mwen_q   <= mwen_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mstrb_q  <= mstrb_d;
      ld_off_q <= ld_off_d;
      ld_sz_q  <= ld_sz_d;
      ld_uns_q <= ld_uns_d;
      exc_q    <= exc_d;
      cause_q  <= cause_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign out_valid     = (state_q == S_DONE);
  assign mem_wen       = mwen_q;
  assign mem_addr      = maddr_q;
  assign mem_wdata     = mwdata_q;
  assign mem_wstrb     = mstrb_q;
  assign out_reg_wen   = wen_q;
  assign out_reg_waddr = waddr_q;
  assign out_reg_wdata = wdata_q;
  assign out_next_pc   = npc_q;
  assign out_exc       = exc_q;
  assign out_exc_cause = cause_q;

endmodule

// File: tb/tb_ysyx_23060203_exu_stage.sv
// Directed scoreboard bench for ysyx_23060203_exu_stage (XLEN=32); EXU_MISALIGN_CHK_EN selects extra steps.
module tb_ysyx_23060203_exu_stage;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_CALRI  = 5'b00100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_src1 = '0, in_src2 = '0, in_imm = '0, in_alu_val = '0;
  logic [4:0]  in_opcode = '0, in_rd = '0;
  logic [2:0]  in_funct = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_rsp_valid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wstrb;
  logic        out_valid, out_ready = 1'b0, out_reg_wen, out_exc;
  logic [4:0]  out_reg_waddr;
  logic [31:0] out_reg_wdata, out_next_pc;
  logic [3:0]  out_exc_cause;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] npc;
    logic        exc;
    logic [3:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  ysyx_23060203_exu_stage #(.XLEN(32), .RAW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_opcode(in_opcode),
    .in_funct(in_funct), .in_rd(in_rd), .in_src1(in_src1), .in_src2(in_src2),
    .in_imm(in_imm), .in_alu_val(in_alu_val),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg_wen(out_reg_wen),
    .out_reg_waddr(out_reg_waddr), .out_reg_wdata(out_reg_wdata),
    .out_next_pc(out_next_pc), .out_exc(out_exc), .out_exc_cause(out_exc_cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                      input logic [31:0] npc, input logic exc, input logic [3:0] cause);
    exp_t e;
    e.wen = wen; e.waddr = waddr; e.wdata = wdata; e.npc = npc; e.exc = exc; e.cause = cause;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] op, input logic [2:0] f,
                       input logic [4:0] rd, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] imm, input logic [31:0] alu);
    chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_pc = pc; in_opcode = op; in_funct = f; in_rd = rd;
    in_src1 = s1; in_src2 = s2; in_imm = imm; in_alu_val = alu;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic lsu_req(input string tag, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int delay, input logic rsp_with_req);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_wen"}, {31'd0, mem_wen}, {31'd0, wen});
    chk({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, strb});
    if (wen) chk({tag, "_wdata"}, mem_wdata, wdata);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk({tag, "_hold_valid"}, {31'd0, mem_req_valid}, 32'd1);
      chk({tag, "_hold_addr"}, mem_addr, addr);
      chk({tag, "_hold_wdata"}, mem_wdata, wdata);
      chk({tag, "_hold_wstrb"}, {28'd0, mem_wstrb}, {28'd0, strb});
    end
    mem_req_ready = 1'b1;
    mem_rsp_valid = rsp_with_req;
    mem_rdata     = 32'hDEAD_BEEF;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    chk({tag, "_req_dropped"}, {31'd0, mem_req_valid}, 32'd0);
  endtask

  task automatic lsu_rsp(input string tag, input logic [31:0] rdata, input int delay);
    for (int i = 0; i < delay; i++) begin
      chk({tag, "_no_early_out"}, {31'd0, out_valid}, 32'd0);
      tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int hold);
    exp_t e;
    int   n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      for (int h = 0; h <= hold; h++) begin
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_wen"}, {31'd0, out_reg_wen}, {31'd0, e.wen});
        chk({tag, "_waddr"}, {27'd0, out_reg_waddr}, {27'd0, e.waddr});
        chk({tag, "_wdata"}, out_reg_wdata, e.wdata);
        chk({tag, "_next_pc"}, out_next_pc, e.npc);
        chk({tag, "_exc"}, {31'd0, out_exc}, {31'd0, e.exc});
        chk({tag, "_cause"}, {28'd0, out_exc_cause}, {28'd0, e.cause});
        if (h < hold) tick();
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_retired"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_again"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // reset
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_reg_wen", {31'd0, out_reg_wen}, 32'd0);
    chk("rst_next_pc", out_next_pc, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);

    // ALU op: result visible the cycle after acceptance
    push(1'b1, 5'd5, 32'h15, 32'h8000_0004, 1'b0, 4'd0);
    issue(32'h8000_0000, OP_CALRI, 3'b000, 5'd5, 32'd0, 32'd0, 32'h15, 32'h15);
    chk("addi_latency", {31'd0, out_valid}, 32'd1);
    expect_out("addi", 0);

    // LB with a response alongside the request (ignored) and 3 wait cycles
    push(1'b1, 5'd7, 32'hFFFF_FF80, 32'h8000_0014, 1'b0, 4'd0);
    issue(32'h8000_0010, OP_LOAD, 3'b000, 5'd7, 32'd0, 32'd0, 32'd3, 32'h8000_1003);
    lsu_req("lb", 32'h8000_1000, 1'b0, 32'd0, 4'b0000, 0, 1'b1);
    lsu_rsp("lb", 32'h80AB_CDEF, 3);
    expect_out("lb", 0);

    push(1'b1, 5'd8, 32'h0000_80AB, 32'h0000_0024, 1'b0, 4'd0);
    issue(32'h20, OP_LOAD, 3'b101, 5'd8, 32'd0, 32'd0, 32'd0, 32'h2002);
    lsu_req("lhu", 32'h2000, 1'b0, 32'd0, 4'b0000, 0, 1'b0);
    lsu_rsp("lhu", 32'h80AB_CDEF, 0);
    expect_out("lhu", 0);

    push(1'b1, 5'd9, 32'hCAFE_F00D, 32'h0000_0034, 1'b0, 4'd0);
    issue(32'h30, OP_LOAD, 3'b111, 5'd9, 32'd0, 32'd0, 32'd0, 32'h3004);
    lsu_req("ld_unknown", 32'h3004, 1'b0, 32'd0, 4'b0000, 0, 1'b0);
    lsu_rsp("ld_unknown", 32'hCAFE_F00D, 1);
    expect_out("ld_unknown", 0);

    // stores: lanes replicated, strobes by size and offset, request held while not ready
    push(1'b0, 5'd3, 32'h102, 32'h204, 1'b0, 4'd0);
    issue(32'h200, OP_STORE, 3'b001, 5'd3, 32'd0, 32'h1234_BEEF, 32'd2, 32'h102);
    lsu_req("sh", 32'h100, 1'b1, 32'hBEEF_BEEF, 4'b1100, 2, 1'b0);
    lsu_rsp("sh", 32'd0, 0);
    expect_out("sh", 0);

    push(1'b0, 5'd0, 32'h101, 32'h304, 1'b0, 4'd0);
    issue(32'h300, OP_STORE, 3'b000, 5'd0, 32'd0, 32'h0000_00A5, 32'd1, 32'h101);
    lsu_req("sb", 32'h100, 1'b1, 32'hA5A5_A5A5, 4'b0010, 0, 1'b0);
    lsu_rsp("sb", 32'd0, 0);
    expect_out("sb", 0);

    push(1'b0, 5'd0, 32'hC, 32'h404, 1'b0, 4'd0);
    issue(32'h400, OP_STORE, 3'b010, 5'd0, 32'd0, 32'h1357_9BDF, 32'hC, 32'hC);
    lsu_req("sw", 32'hC, 1'b1, 32'h1357_9BDF, 4'b1111, 1, 1'b0);
    lsu_rsp("sw", 32'd0, 2);
    expect_out("sw", 0);

    // control flow
    push(1'b0, 5'd0, 32'd1, 32'hF8, 1'b0, 4'd0);
    issue(32'h100, OP_BRANCH, 3'b001, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'd1);
    expect_out("bne_taken", 0);

    push(1'b0, 5'd0, 32'd1, 32'h104, 1'b0, 4'd0);
    issue(32'h100, OP_BRANCH, 3'b000, 5'd0, 32'd0, 32'd0, 32'h40, 32'd1);
    expect_out("beq_not_taken", 0);

    push(1'b0, 5'd0, 32'd0, 32'h140, 1'b0, 4'd0);
    issue(32'h100, OP_BRANCH, 3'b101, 5'd0, 32'd0, 32'd0, 32'h40, 32'd0);
    expect_out("bge_taken", 0);

    push(1'b0, 5'd0, 32'd0, 32'h104, 1'b0, 4'd0);
    issue(32'h100, OP_BRANCH, 3'b010, 5'd0, 32'd0, 32'd0, 32'h40, 32'd0);
    expect_out("br_f010", 0);

    push(1'b1, 5'd1, 32'h104, 32'h202, 1'b0, 4'd0);
    issue(32'h100, OP_JALR, 3'b000, 5'd1, 32'h203, 32'd0, 32'd0, 32'h104);
    expect_out("jalr", 0);

    push(1'b1, 5'd1, 32'd0, 32'h4, 1'b0, 4'd0);
    issue(32'hFFFF_FFFC, OP_JAL, 3'b000, 5'd1, 32'd0, 32'd0, 32'd8, 32'd0);
    expect_out("jal_wrap", 0);

    push(1'b1, 5'd9, 32'h1234_5000, 32'h504, 1'b0, 4'd0);
    issue(32'h500, OP_LUI, 3'b000, 5'd9, 32'd0, 32'd0, 32'h1234_5000, 32'h1234_5000);
    expect_out("lui", 0);

    push(1'b0, 5'd4, 32'h77, 32'h604, 1'b0, 4'd0);
    issue(32'h600, 5'b11111, 3'b000, 5'd4, 32'd0, 32'd0, 32'd0, 32'h77);
    expect_out("unknown_op", 0);

    // reset during WAIT drops the transaction; late response in IDLE ignored
    issue(32'h700, OP_LOAD, 3'b010, 5'd6, 32'd0, 32'd0, 32'd0, 32'h40);
    lsu_req("lw_abort", 32'h40, 1'b0, 32'd0, 4'b0000, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_wdata", out_reg_wdata, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h5555_AAAA;
    tick();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_out_valid", {31'd0, out_valid}, 32'd0);
    chk("late_rsp_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("late_rsp_out_valid2", {31'd0, out_valid}, 32'd0);

    // WBU back-pressure: outputs held for 5 cycles
    push(1'b1, 5'd2, 32'h7, 32'h804, 1'b0, 4'd0);
    issue(32'h800, OP_CALRI, 3'b000, 5'd2, 32'd0, 32'd0, 32'd7, 32'h7);
    expect_out("hold", 5);

`ifdef EXU_MISALIGN_CHK_EN
    push(1'b0, 5'd4, 32'h2, 32'h904, 1'b1, 4'd4);
    issue(32'h900, OP_LOAD, 3'b010, 5'd4, 32'd0, 32'd0, 32'd2, 32'h2);
    chk("mis_lw_no_req", {31'd0, mem_req_valid}, 32'd0);
    expect_out("mis_lw", 0);

    push(1'b0, 5'd0, 32'h103, 32'hA04, 1'b1, 4'd6);
    issue(32'hA00, OP_STORE, 3'b001, 5'd0, 32'd0, 32'h1111, 32'd3, 32'h103);
    chk("mis_sh_no_req", {31'd0, mem_req_valid}, 32'd0);
    expect_out("mis_sh", 0);
`else
    push(1'b1, 5'd4, 32'h1122_3344, 32'h904, 1'b0, 4'd0);
    issue(32'h900, OP_LOAD, 3'b010, 5'd4, 32'd0, 32'd0, 32'd6, 32'h6);
    lsu_req("mis_lw", 32'h4, 1'b0, 32'd0, 4'b0000, 0, 1'b0);
    lsu_rsp("mis_lw", 32'h1122_3344, 0);
    expect_out("mis_lw", 0);
`endif

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
